// File: rtl/branch_pkg.sv
// Shared funct3 encodings and branch-kind decode for the branch resolution stage.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    BK_EQ,
    BK_NE,
    BK_LT,
    BK_GE,
    BK_LTU,
    BK_GEU,
    BK_ILLEGAL
  } branch_kind_e;

  // 010 and 011 have no conditional-branch meaning and fall to BK_ILLEGAL.
  function automatic branch_kind_e decode_kind(input logic [2:0] f3);
    case (f3)
      F3_BEQ:  return BK_EQ;
      F3_BNE:  return BK_NE;
      F3_BLT:  return BK_LT;
      F3_BGE:  return BK_GE;
      F3_BLTU: return BK_LTU;
      F3_BGEU: return BK_GEU;
      default: return BK_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational operand comparator: equality, signed and unsigned less-than.
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            eq,
  output logic            lt,
  output logic            ltu
);

  logic [XLEN:0] diff;

  assign diff = {1'b0, src1} - {1'b0, src2};
  assign ltu  = diff[XLEN];
  // The low XLEN bits of the difference are zero exactly when the operands match.
  assign eq   = (diff[XLEN-1:0] == '0);
  assign lt   = (src1[XLEN-1] == src2[XLEN-1]) ? ltu : src1[XLEN-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage with valid/ready output and flush.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  src1,
  input  logic [XLEN-1:0]  src2,
  input  logic             pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
`ifdef BRANCH_STATS_EN
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts,
`endif
  output logic             out_illegal
);

  if (XLEN < 2 || CNT_W < 1) begin : g_param_check
    $error("branch_resolve_unit: XLEN must be >= 2 and CNT_W >= 1");
  end

  logic         eq, lt, ltu;
  branch_kind_e kind;
  logic         res_taken, res_illegal, res_mispredict;
  logic         accept, done;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .src1 (src1),
    .src2 (src2),
    .eq   (eq),
    .lt   (lt),
    .ltu  (ltu)
  );

  assign kind = decode_kind(funct3);

  always_comb begin
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    case (kind)
      BK_EQ:   res_taken = eq;
      BK_NE:   res_taken = !eq;
      BK_LT:   res_taken = lt;
      BK_GE:   res_taken = !lt;
      BK_LTU:  res_taken = ltu;
      BK_GEU:  res_taken = !ltu;
      default: res_illegal = 1'b1;
    endcase
    res_mispredict = !res_illegal && (res_taken != pred_taken);
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and the held payload stays stable
  // while out_valid is high and out_ready is low.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign done     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      out_illegal    <= 1'b0;
    end else begin
      if (flush)       out_valid <= 1'b0;
      else if (accept) out_valid <= 1'b1;
      else if (done)   out_valid <= 1'b0;

      if (accept) begin
        out_taken      <= res_taken;
        out_mispredict <= res_mispredict;
        out_illegal    <= res_illegal;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  // A handshake in a flush cycle still completes, so counting ignores flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (done && !out_illegal) begin
      if (stat_branches != '1)
        stat_branches <= stat_branches + CNT_W'(1);
      if (out_mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (stats checks when BRANCH_STATS_EN).
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  src1;
  logic [XLEN-1:0]  src2;
  logic             pred_taken;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_taken;
  logic             out_mispredict;
  logic             out_illegal;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .funct3           (funct3),
    .src1             (src1),
    .src2             (src2),
    .pred_taken       (pred_taken),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_taken        (out_taken),
    .out_mispredict   (out_mispredict),
`ifdef BRANCH_STATS_EN
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
`endif
    .out_illegal      (out_illegal)
  );

  int n_cmp = 0;
  int n_err = 0;

  // expected {taken, mispredict, illegal}
  logic [2:0] exp_q[$];

  typedef struct {
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            p;
    logic [2:0]      exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic p);
    in_valid   = 1'b1;
    funct3     = f3;
    src1       = a;
    src2       = b;
    pred_taken = p;
  endtask

  initial begin
    vecs[0] = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b110}; // BLT
    vecs[1] = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b000}; // BLTU
    vecs[2] = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b110}; // BGEU
    vecs[3] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b100}; // BEQ
    vecs[4] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b010}; // BNE
    vecs[5] = '{3'b010, 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b001}; // illegal
    vecs[6] = '{3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b000}; // BGE
    vecs[7] = '{3'b110, 32'h0000_0000, 32'h0000_0000, 1'b1, 3'b010}; // BLTU
    vecs[8] = '{3'b101, 32'h0000_0003, 32'h0000_0003, 1'b1, 3'b100}; // BGE
    vecs[9] = '{3'b011, 32'h0000_0001, 32'h0000_0002, 1'b0, 3'b001}; // illegal

    rst = 1'b1; in_valid = 1'b0; funct3 = 3'b000; src1 = '0; src2 = '0;
    pred_taken = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_taken", 32'(out_taken), 32'd0);
    check("rst_out_mispredict", 32'(out_mispredict), 32'd0);
    check("rst_out_illegal", 32'(out_illegal), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BRANCH_STATS_EN
    check("rst_stat_branches", 32'(stat_branches), 32'd0);
    check("rst_stat_mispredicts", 32'(stat_mispredicts), 32'd0);
`endif

    // Back-to-back stream with out_ready high: one result per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].p);
      exp_q.push_back(vecs[i].exp);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      if (exp_q.size() != 0)
        check($sformatf("vec%0d_result", i),
              32'({out_taken, out_mispredict, out_illegal}), 32'(exp_q.pop_front()));
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
`ifdef BRANCH_STATS_EN
    check("stream_stat_branches", 32'(stat_branches), 32'd8);
    check("stream_stat_mispredicts", 32'(stat_mispredicts), 32'd4);
`endif

    // Backpressure: BGE 5,3 pred 1 held while a BNE waits at the input.
    out_ready = 1'b0;
    drive(3'b101, 32'd5, 32'd3, 1'b1);
    tick();
    check("hold_first_valid", 32'(out_valid), 32'd1);
    drive(3'b001, 32'd1, 32'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
      tick();
      check($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_payload", i),
            32'({out_taken, out_mispredict, out_illegal}), 32'b100);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("nobubble_valid", 32'(out_valid), 32'd1);
    check("nobubble_payload", 32'({out_taken, out_mispredict, out_illegal}), 32'b010);

    // Flush while a result is held and a new request is presented.
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    check("preflush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    drive(3'b000, 32'd7, 32'd7, 1'b0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("postflush%0d_valid", i), 32'(out_valid), 32'd0);
    end
`ifdef BRANCH_STATS_EN
    check("flush_stat_branches", 32'(stat_branches), 32'd9);
    check("flush_stat_mispredicts", 32'(stat_mispredicts), 32'd4);
`endif

    // Flush coinciding with an output handshake: the handshake still completes.
    drive(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_hs_valid", 32'(out_valid), 32'd0);
`ifdef BRANCH_STATS_EN
    check("flush_hs_stat_branches", 32'(stat_branches), 32'd10);
    check("flush_hs_stat_mispredicts", 32'(stat_mispredicts), 32'd5);

    // Saturation at CNT_W=4 after 20 mispredicted legal branches.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_stat_branches", 32'(stat_branches), 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("sat_stat_branches", 32'(stat_branches), 32'hF);
    check("sat_stat_mispredicts", 32'(stat_mispredicts), 32'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst3_stat_branches", 32'(stat_branches), 32'd0);
    check("rst3_stat_mispredicts", 32'(stat_mispredicts), 32'd0);
`endif

    // Reset mid-transaction discards the held result.
    out_ready = 1'b0;
    drive(3'b000, 32'd4, 32'd4, 1'b0);
    tick();
    in_valid = 1'b0;
    check("prerst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_taken", 32'(out_taken), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
